// File: rtl/ksa32_sub_pipe.sv
// rtl/ksa32_sub_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready handshakes
module ksa32_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int L = $clog2(WIDTH);

  // Group-propagate half of the prefix network over levels first_lvl..last_lvl.
  // Level k combines bit i with bit i-2^(k-1); lower bits pass through.
  function automatic logic [WIDTH-1:0] prefix_p(input logic [WIDTH-1:0] p_in,
                                                input int first_lvl, input int last_lvl);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] pn;
    int d;
    int j;
    p = p_in;
    for (int lvl = 1; lvl <= L; lvl++) begin
      if (lvl >= first_lvl && lvl <= last_lvl) begin
        d = 1 << (lvl - 1);
        for (int i = 0; i < WIDTH; i++) begin
          j = (i >= d) ? i - d : 0;
          pn[i] = (i >= d) ? (p[i] & p[j]) : p[i];
        end
        p = pn;
      end
    end
    return p;
  endfunction

  // Group-generate half: Go = Gi | (Pi & Gj), tracking the group P alongside.
  function automatic logic [WIDTH-1:0] prefix_g(input logic [WIDTH-1:0] p_in,
                                                input logic [WIDTH-1:0] g_in,
                                                input int first_lvl, input int last_lvl);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pn;
    logic [WIDTH-1:0] gn;
    int d;
    int j;
    p = p_in;
    g = g_in;
    for (int lvl = 1; lvl <= L; lvl++) begin
      if (lvl >= first_lvl && lvl <= last_lvl) begin
        d = 1 << (lvl - 1);
        for (int i = 0; i < WIDTH; i++) begin
          j = (i >= d) ? i - d : 0;
          gn[i] = (i >= d) ? (g[i] | (p[i] & g[j])) : g[i];
          pn[i] = (i >= d) ? (p[i] & p[j]) : p[i];
        end
        p = pn;
        g = gn;
      end
    end
    return g;
  endfunction

  logic             en;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic             cin1_q, cin1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] gp2_q, gp2_d;
  logic [WIDTH-1:0] gg2_q, gg2_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic             cin2_q, cin2_d;

  logic             v3_q, v3_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic             c3_q, c3_d;
  logic             bw3_q, bw3_d;
  logic             ov3_q, ov3_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_seed;
  logic [WIDTH-1:0] g_fin;
  logic [WIDTH:0]   carry;

  // Whole pipe advances together; it only freezes while a result is stuck at the output.
  always_comb begin
    en       = ~v3_q | out_ready;
    in_ready = en;
  end

  // Stage 1: bitwise P/G of A and the conditionally inverted B; sub seeds the carry-in.
  always_comb begin
    b_eff  = b_i ^ {WIDTH{sub_i}};
    v1_d   = v1_q;
    p1_d   = p1_q;
    g1_d   = g1_q;
    x1_d   = x1_q;
    cin1_d = cin1_q;
    if (en) begin
      v1_d   = in_valid;
      p1_d   = a_i ^ b_eff;
      g1_d   = a_i & b_eff;
      x1_d   = a_i ^ b_eff;
      cin1_d = sub_i;
    end
  end

  // Stage 2: fold cin into bit 0 as G[-1], then the low prefix levels.
  always_comb begin
    g_seed    = g1_q;
    g_seed[0] = g1_q[0] | (p1_q[0] & cin1_q);
    v2_d      = v2_q;
    gp2_d     = gp2_q;
    gg2_d     = gg2_q;
    x2_d      = x2_q;
    cin2_d    = cin2_q;
    if (en) begin
      v2_d   = v1_q;
      gp2_d  = prefix_p(p1_q, 1, SPLIT);
      gg2_d  = prefix_g(p1_q, g_seed, 1, SPLIT);
      x2_d   = x1_q;
      cin2_d = cin1_q;
    end
  end

  // Stage 3: remaining prefix levels, then sum and flags from the carry vector.
  always_comb begin
    g_fin = prefix_g(gp2_q, gg2_q, SPLIT + 1, L);
    carry = {g_fin, cin2_q};
    v3_d  = v3_q;
    s3_d  = s3_q;
    c3_d  = c3_q;
    bw3_d = bw3_q;
    ov3_d = ov3_q;
    if (en) begin
      v3_d  = v2_q;
      s3_d  = x2_q ^ carry[WIDTH-1:0];
      c3_d  = carry[WIDTH];
      bw3_d = cin2_q & ~carry[WIDTH];
      ov3_d = carry[WIDTH-1] ^ carry[WIDTH];
    end
  end

  // All pipeline state, cleared together on reset so in-flight beats vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      p1_q   <= '0;
      g1_q   <= '0;
      x1_q   <= '0;
      cin1_q <= 1'b0;
      v2_q   <= 1'b0;
      gp2_q  <= '0;
      gg2_q  <= '0;
      x2_q   <= '0;
      cin2_q <= 1'b0;
      v3_q   <= 1'b0;
      s3_q   <= '0;
      c3_q   <= 1'b0;
      bw3_q  <= 1'b0;
      ov3_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      p1_q   <= p1_d;
      g1_q   <= g1_d;
      x1_q   <= x1_d;
      cin1_q <= cin1_d;
      v2_q   <= v2_d;
      gp2_q  <= gp2_d;
      gg2_q  <= gg2_d;
      x2_q   <= x2_d;
      cin2_q <= cin2_d;
      v3_q   <= v3_d;
      s3_q   <= s3_d;
      c3_q   <= c3_d;
      bw3_q  <= bw3_d;
      ov3_q  <= ov3_d;
    end
  end

  assign out_valid = v3_q;
  assign s_o       = s3_q;
  assign c_o       = c3_q;
  assign borrow_o  = bw3_q;
  assign ovf_o     = ov3_q;

endmodule

// File: doc/ksa32_sub_pipe.md
Name: ksa32_sub_pipe

Overview:
Pipelined 32-bit Kogge-Stone adder/subtractor with valid/ready handshakes on both sides. It is the inverse-direction companion to the KSA32 prefix stages: it computes A-B (or A+B) using the same P/G prefix network, cut into registered stages. It sits in the datapath wherever a single-cycle KSA32 misses timing, for example in ALU and address-compare paths.

Parameters:
WIDTH, 32, operand width; power of two, 8..64; prefix levels L = log2(WIDTH), which is 5 at the default.
SPLIT, 3, number of prefix levels evaluated before the mid-pipe register; range 1..L-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts the beat this cycle
a_i  input  WIDTH  minuend / first addend
b_i  input  WIDTH  subtrahend / second addend
sub_i  input  1  1 = A-B, 0 = A+B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
s_o  output  WIDTH  difference / sum
c_o  output  1  raw carry-out of the MSB
borrow_o  output  1  sub & ~carry-out; 0 in add mode
ovf_o  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous and active-high. On a clk edge with rst=1:
  - out_valid, s_o, c_o, borrow_o and ovf_o are cleared to 0.
  - All internal valid bits and stage data registers are cleared to 0.
  - in_ready reads 1 during and after reset.
  - Reset mid-operation drops every in-flight beat; nothing emerges afterwards.
- Pipeline: 3 register stages, latency exactly 3 cycles from the accepting edge to out_valid with no stall.
  - Stage 1 (accept edge): register P = A^B', G = A&B', where B' = B^{WIDTH{sub}}. Register cin = sub as the prefix seed G[-1]. Also register A^B' for sum formation.
  - Stage 2: run prefix levels 1..SPLIT (distances 1,2,4,...) with the cin seed folded into bit 0; register the group P/G.
  - Stage 3: run the remaining levels SPLIT+1..L.
    - Carries: c[0] = cin, c[i+1] = group G[i].
    - Outputs: s = P ^ c[WIDTH-1:0], c_o = c[WIDTH], ovf_o = c[WIDTH-1]^c[WIDTH], borrow_o = sub & ~c[WIDTH].
    - Register all outputs and set out_valid.
- Prefix cell: the same (Pi,Pj,Gi,Gj) combine used by the KSA32 stages.
  - Go = Gi | (Pi & Gj); Po = Pi & Pj.
  - Bits below the current distance pass through unchanged.
- Handshake:
  - Global enable en = ~out_valid | out_ready; in_ready = en (combinational, no dependency on in_valid).
  - A beat transfers when in_valid & in_ready.
  - When en=0, every stage register and valid bit holds its value; s_o and the other outputs stay stable while out_valid=1 and out_ready=0.
  - The upstream may drop in_valid at any time when in_ready=0; the block does not latch it.
  - Bubbles: a stage with valid=0 still advances when en=1. Empty slots are not compressed ahead of a stalled output.
- Throughput: 1 result per cycle when out_ready is held at 1. No beat is lost or duplicated across any stall pattern.
- Simultaneous out_ready and in_valid with a full pipe: the output retires and the new beat enters on the same edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Boundary cases:
  - A=B in sub mode gives s=0, c_o=1, borrow_o=0.
  - 0-1 gives all-ones, borrow_o=1.

Test Plan:
- Reset then one beat a=0x0000_0005, b=0x0000_0003, sub=1, out_ready=1 -> out_valid rises exactly 3 cycles later. Expect s=0x0000_0002, c_o=1, borrow_o=0, ovf_o=0.
- a=0, b=1, sub=1 -> s=0xFFFF_FFFF, borrow_o=1, c_o=0, ovf_o=0. Add mode a=0xFFFF_FFFF, b=1 -> s=0, c_o=1, borrow_o=0.
- Signed overflow: sub a=0x8000_0000, b=1 -> s=0x7FFF_FFFF, ovf_o=1. Add a=0x7FFF_FFFF, b=1 -> s=0x8000_0000, ovf_o=1.
- Backpressure: stream 8 random beats with out_ready toggled pseudo-randomly -> results match a model in order. Outputs are stable while stalled; in_ready==(~out_valid|out_ready) every cycle.
- Full throughput: 1000 back-to-back random beats (both modes), out_ready=1 -> one result per cycle after 3-cycle fill, all matching (a±b) mod 2^32 with flags.
- Reset mid-flight: accept 3 beats, assert rst 1 cycle -> out_valid=0 next cycle and no old results appear. The next beat 0x10-0x08 yields 0x08 after 3 cycles.
